feed_frame_encoder: RTL and testbench

- Synthesizable successor to the NanoTrade bench's hand-written price/volume/buy/sell drive tasks.
- Accepts wide market messages over valid/ready, buffers them in a parametrised FIFO, and serialises each into one or more beats of the tt_um_nanotrade pin encoding.
- Beat encoding: ui = {opcode[1:0], payload[5:0]}, uio = {flags, payload_hi[5:0]}.
- Sits between an on-chip/FPGA replay source and the nanotrade core; supports multi-beat widths, inter-message gaps, pause and flush.

---
 rtl/feed_frame_encoder.sv | 102 ++++++++++
 tb/tb_feed_frame_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/feed_frame_encoder.sv
// feed_frame_encoder: FIFO-buffered market messages serialised into nanotrade ui/uio beats; FEED_FRAME_PARITY_EN adds even parity on uio_out[7].
module feed_frame_encoder #(
  parameter int DATA_W = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int IDLE_GAP = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic msg_valid,
  output logic msg_ready,
  input  logic [1:0] msg_type,
  input  logic [DATA_W-1:0] msg_data,
  input  logic out_en,
  input  logic flush,
  output logic [7:0] ui_out,
  output logic [7:0] uio_out,
  output logic out_valid,
  output logic out_sop,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic busy
);
  localparam int BEATS = DATA_W / 12;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [1:0] LAST_B = 2'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state;
  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W+1:0] head;
  logic [1:0] beat, hold_type;
  logic [DATA_W-1:0] hold_data;
  logic [3:0] gap_cnt;
  logic clr, full, empty, push, pop, last, start;
  assign clr = rst || flush;
  assign full = fifo_level == LW'(FIFO_DEPTH);
  assign empty = fifo_level == '0;
  assign msg_ready = !full;
  assign push = msg_valid && !full;
  assign head = mem[rd_ptr];
  assign last = hold_type[1] || beat == LAST_B;
  assign start = !empty && out_en;
  assign pop = start && (state == IDLE || (state == SEND && last && IDLE_GAP == 0) ||
                         (state == GAP && gap_cnt == 4'(IDLE_GAP)));
  assign busy = state != IDLE;
  // Returns {ui, uio}; buy/sell carry only data[5:0] and never chain.
  function automatic logic [15:0] encode(input logic [1:0] t, input logic [DATA_W-1:0] d,
                                         input logic [1:0] k, input logic lst);
    logic [11:0] s;
    logic [15:0] w;
    s = 12'(d >> (12 * k));
    w = t[1] ? {t, d[5:0], 8'h00} : {t, s[5:0], 1'b0, !lst, s[11:6]};
`ifdef FEED_FRAME_PARITY_EN
    w[7] = ^w;
`endif
    return w;
  endfunction
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {msg_type, msg_data};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      beat <= '0;
      gap_cnt <= '0;
      hold_type <= '0;
      hold_data <= '0;
      {ui_out, uio_out} <= '0;
      out_valid <= 1'b0;
      out_sop <= 1'b0;
    end else if (pop) begin
      state <= SEND;
      beat <= '0;
      {hold_type, hold_data} <= head;
      {ui_out, uio_out} <= encode(head[DATA_W+1 -: 2], head[DATA_W-1:0], 2'd0,
                                  head[DATA_W+1] || BEATS == 1);
      out_valid <= 1'b1;
      out_sop <= 1'b1;
    end else if (state == SEND && !last) begin
      beat <= beat + 2'd1;
      {ui_out, uio_out} <= encode(hold_type, hold_data, beat + 2'd1, beat + 2'd1 == LAST_B);
      out_sop <= 1'b0;
    end else begin
      state <= (state == SEND && IDLE_GAP > 0) || (state == GAP && gap_cnt != 4'(IDLE_GAP)) ? GAP : IDLE;
      gap_cnt <= state == GAP ? gap_cnt + 4'd1 : 4'd1;
      {ui_out, uio_out} <= '0;
      out_valid <= 1'b0;
      out_sop <= 1'b0;
    end
  end
endmodule

// File: tb/tb_feed_frame_encoder.sv
// tb_feed_frame_encoder: directed checks on default, 24-bit and IDLE_GAP=3 instances sharing one stimulus bus.
module tb_feed_frame_encoder;
`ifdef FEED_FRAME_PARITY_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif
  localparam logic [7:0] GT [13] = '{8'h8A, 8'h00, 8'h00, 8'h00, 8'hCA, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] AT [4] = '{8'h8A, 8'hCA, 8'h64, 8'h00};
  logic clk = 1'b0, rst = 1'b1, msg_valid = 1'b0, out_en = 1'b0, flush = 1'b0;
  logic [1:0] msg_type = 2'd0;
  logic [23:0] msg_data = '0;
  logic [7:0] a_ui, a_uio, w_ui, w_uio, g_ui, g_uio;
  logic a_valid, a_sop, a_ready, a_busy, w_valid, w_sop, w_ready, w_busy, g_valid, g_sop, g_ready, g_busy;
  logic [3:0] a_level, w_level, g_level;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  feed_frame_encoder u_a (.clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(a_ready), .msg_type(msg_type),
    .msg_data(msg_data[11:0]), .out_en(out_en), .flush(flush), .ui_out(a_ui), .uio_out(a_uio),
    .out_valid(a_valid), .out_sop(a_sop), .fifo_level(a_level), .busy(a_busy));
  feed_frame_encoder #(.DATA_W(24)) u_w (.clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(w_ready),
    .msg_type(msg_type), .msg_data(msg_data), .out_en(out_en), .flush(flush), .ui_out(w_ui), .uio_out(w_uio),
    .out_valid(w_valid), .out_sop(w_sop), .fifo_level(w_level), .busy(w_busy));
  feed_frame_encoder #(.IDLE_GAP(3)) u_g (.clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(g_ready),
    .msg_type(msg_type), .msg_data(msg_data[11:0]), .out_en(out_en), .flush(flush), .ui_out(g_ui), .uio_out(g_uio),
    .out_valid(g_valid), .out_sop(g_sop), .fifo_level(g_level), .busy(g_busy));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1; msg_valid = 1'b0; flush = 1'b0; out_en = 1'b0;
    step;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    checks++; if (a_ui !== 8'h00) begin errors++; $display("FAIL reset_ui: got %h expected 00", a_ui); end
    checks++; if (a_uio !== 8'h00) begin errors++; $display("FAIL reset_uio: got %h expected 00", a_uio); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    checks++; if (a_sop !== 1'b0) begin errors++; $display("FAIL reset_sop: got %b expected 0", a_sop); end
    checks++; if (a_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", a_level); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    checks++; if (g_ready !== 1'b1 || w_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_other: got %b%b expected 11", g_ready, w_ready); end
    rst = 1'b0;
  endtask
  task automatic test_single_price;
    do_reset;
    out_en = 1'b1; msg_type = 2'd0; msg_data = 24'd100; msg_valid = 1'b1;
    step;
    msg_valid = 1'b0;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL price_early: got %b expected 0", a_valid); end
    step;
    checks++; if (a_ui !== 8'h24) begin errors++; $display("FAIL price_ui: got %h expected 24", a_ui); end
    checks++; if (a_uio !== (P ? 8'h81 : 8'h01)) begin errors++; $display("FAIL price_uio: got %h expected %h", a_uio, P ? 8'h81 : 8'h01); end
    checks++; if (a_valid !== 1'b1 || a_sop !== 1'b1) begin errors++; $display("FAIL price_valid_sop: got %b%b expected 11", a_valid, a_sop); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL price_busy: got %b expected 1", a_busy); end
    step;
    checks++; if (a_valid !== 1'b0 || a_ui !== 8'h00) begin errors++; $display("FAIL price_after: got %b/%h expected 0/00", a_valid, a_ui); end
  endtask
  task automatic test_wide;
    do_reset;
    out_en = 1'b1; msg_type = 2'd0; msg_data = 24'h123456; msg_valid = 1'b1;
    step;
    msg_valid = 1'b0;
    step;
    checks++; if (w_ui !== 8'h16 || w_uio !== 8'h51) begin errors++; $display("FAIL wide_b0: got %h/%h expected 16/51", w_ui, w_uio); end
    checks++; if (w_valid !== 1'b1 || w_sop !== 1'b1) begin errors++; $display("FAIL wide_b0_flags: got %b%b expected 11", w_valid, w_sop); end
    step;
    checks++; if (w_ui !== 8'h23 || w_uio !== 8'h04) begin errors++; $display("FAIL wide_b1: got %h/%h expected 23/04", w_ui, w_uio); end
    checks++; if (w_valid !== 1'b1 || w_sop !== 1'b0) begin errors++; $display("FAIL wide_b1_flags: got %b%b expected 10", w_valid, w_sop); end
    step;
    checks++; if (w_valid !== 1'b0 || w_ui !== 8'h00) begin errors++; $display("FAIL wide_idle: got %b/%h expected 0/00", w_valid, w_ui); end
  endtask
  task automatic test_back_to_back;
    do_reset;
    out_en = 1'b1; msg_type = 2'd2; msg_data = 24'd10; msg_valid = 1'b1;
    step;
    msg_type = 2'd3;
    for (int i = 0; i < 13; i++) begin
      step;
      checks++; if (g_ui !== GT[i] || g_valid !== (GT[i] != 8'h00)) begin errors++; $display("FAIL gap_beat%0d: got %h/%b expected %h/%b", i, g_ui, g_valid, GT[i], GT[i] != 8'h00); end
      checks++; if (g_busy !== (i < 12) || g_sop !== g_valid) begin errors++; $display("FAIL gap_busy%0d: got %b/%b expected %b/%b", i, g_busy, g_sop, i < 12, GT[i] != 8'h00); end
      if (i < 4) begin
        checks++; if (a_ui !== AT[i] || a_valid !== (i < 3)) begin errors++; $display("FAIL b2b_beat%0d: got %h/%b expected %h/%b", i, a_ui, a_valid, AT[i], i < 3); end
      end
      if (i == 2) begin
        checks++; if (a_uio !== 8'h01) begin errors++; $display("FAIL b2b_vol_uio: got %h expected 01", a_uio); end
      end
      if (i == 0) begin msg_type = 2'd0; msg_data = 24'd100; msg_type = 2'd1; end
      if (i == 1) msg_valid = 1'b0;
    end
  endtask
  task automatic test_fifo_full;
    int got;
    logic acc;
    do_reset;
    msg_type = 2'd0; msg_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      msg_data = 24'(i + 1);
      step;
    end
    msg_data = 24'd9;
    checks++; if (a_ready !== 1'b0 || a_level !== 4'd8) begin errors++; $display("FAIL full_flag: got %b/%0d expected 0/8", a_ready, a_level); end
    step;
    step;
    checks++; if (a_ready !== 1'b0 || a_level !== 4'd8) begin errors++; $display("FAIL full_hold: got %b/%0d expected 0/8", a_ready, a_level); end
    out_en = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 9; c++) begin
      acc = msg_valid && a_ready;
      step;
      if (acc) msg_valid = 1'b0;
      if (a_valid) begin
        checks++; if (a_ui !== 8'(got + 1)) begin errors++; $display("FAIL full_order%0d: got %h expected %h", got, a_ui, 8'(got + 1)); end
        got++;
      end
    end
    checks++; if (got !== 9) begin errors++; $display("FAIL full_count: got %0d expected 9", got); end
    checks++; if (a_level !== 4'd0 || msg_valid !== 1'b0) begin errors++; $display("FAIL full_drain: got %0d/%b expected 0/0", a_level, msg_valid); end
  endtask
  task automatic test_pause_flush;
    do_reset;
    out_en = 1'b1; msg_type = 2'd0; msg_data = 24'h123456; msg_valid = 1'b1;
    step;
    msg_data = 24'h000001;
    step;
    msg_valid = 1'b0; out_en = 1'b0;
    checks++; if (w_ui !== 8'h16 || w_sop !== 1'b1) begin errors++; $display("FAIL pause_b0: got %h/%b expected 16/1", w_ui, w_sop); end
    step;
    checks++; if (w_ui !== 8'h23 || w_valid !== 1'b1) begin errors++; $display("FAIL pause_b1: got %h/%b expected 23/1", w_ui, w_valid); end
    step;
    checks++; if (w_valid !== 1'b0 || w_busy !== 1'b0 || w_level !== 4'd1) begin errors++; $display("FAIL pause_stop: got %b/%b/%0d expected 0/0/1", w_valid, w_busy, w_level); end
    step;
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL pause_hold: got %b expected 0", w_valid); end
    out_en = 1'b1;
    step;
    checks++; if (w_ui !== 8'h01 || w_uio !== 8'h40 || w_sop !== 1'b1) begin errors++; $display("FAIL resume_b0: got %h/%h/%b expected 01/40/1", w_ui, w_uio, w_sop); end
    flush = 1'b1; msg_valid = 1'b1; msg_data = 24'h000abc;
    step;
    flush = 1'b0; msg_valid = 1'b0;
    checks++; if (w_valid !== 1'b0 || w_ui !== 8'h00 || w_uio !== 8'h00) begin errors++; $display("FAIL flush_out: got %b/%h/%h expected 0/00/00", w_valid, w_ui, w_uio); end
    checks++; if (w_level !== 4'd0 || w_ready !== 1'b1 || w_busy !== 1'b0) begin errors++; $display("FAIL flush_state: got %0d/%b/%b expected 0/1/0", w_level, w_ready, w_busy); end
    step;
    checks++; if (w_valid !== 1'b0 || w_level !== 4'd0) begin errors++; $display("FAIL flush_after: got %b/%0d expected 0/0", w_valid, w_level); end
  endtask
  initial begin
    test_reset;
    test_single_price;
    test_wide;
    test_back_to_back;
    test_fifo_full;
    test_pause_flush;
    checks++; if (g_level !== 4'd0 || g_uio !== 8'h00) begin errors++; $display("FAIL final_idle: got %0d/%h expected 0/00", g_level, g_uio); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
